// File: rtl/inst_fetch.sv
// Instruction fetch unit.
// Keeps a program counter and drives it to an instruction ROM that
// answers combinationally. It registers the returned word, together with
// the address it came from, as the fetched instruction. Sequencing is a
// three-state machine: IDLE, FETCH and HALTED. Stall, branch redirect and
// halt requests are all resolved once per cycle. While fetching, halt
// takes priority over stall, and stall takes priority over branch.
module inst_fetch #(
    parameter int IW = 16,
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [IW-1:0] i_start_addr,
    input  logic          i_stall,
    input  logic          i_branch_en,
    input  logic [IW-1:0] i_branch_target,
    input  logic          i_halt_req,
    output logic [IW-1:0] o_inst_address,
    input  logic [DW-1:0] i_inst_in,
    output logic [DW-1:0] o_inst_out,
    output logic          o_inst_valid,
    output logic [IW-1:0] o_pc_out,
    output logic          o_done,
    output logic [15:0]   o_inst_count
);

    // State encoding. Code 2'b11 is unreachable and is treated as IDLE
    // so that a corrupted state register can still recover on Start.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [IW-1:0] PC_ONE    = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   COUNT_MAX = 16'hFFFF;

    // Architectural state
    logic [1:0]    r_state;
    logic [IW-1:0] r_pc;
    logic [DW-1:0] r_inst_out;
    logic [IW-1:0] r_pc_out;
    logic          r_inst_valid;
    logic [15:0]   r_inst_count;

    // Per-cycle action decode
    logic          w_waiting;
    logic          w_fetching;
    logic          w_do_start;
    logic          w_do_halt;
    logic          w_do_stall;
    logic          w_do_branch;
    logic          w_do_seq;

    // Next-state values
    logic [1:0]    w_state_nxt;
    logic [IW-1:0] w_pc_nxt;
    logic [DW-1:0] w_inst_out_nxt;
    logic [IW-1:0] w_pc_out_nxt;
    logic          w_inst_valid_nxt;
    logic [15:0]   w_inst_count_nxt;

    // The delivered-instruction count sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == COUNT_MAX) begin
            sat_inc16 = COUNT_MAX;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

    // Classify the current cycle into exactly one action according to the
    // FETCH priority order. Start and branch requests are decoded only in
    // the states where they have an effect.
    always_comb begin
        w_fetching  = (r_state == S_FETCH);
        w_waiting   = !w_fetching;
        w_do_start  = w_waiting && i_start;
        w_do_halt   = w_fetching && i_halt_req;
        w_do_stall  = w_fetching && !i_halt_req && i_stall;
        w_do_branch = w_fetching && !i_halt_req && !i_stall && i_branch_en;
        w_do_seq    = w_fetching && !i_halt_req && !i_stall && !i_branch_en;
    end

    // Compute next values for every register. The default is to hold, so
    // the stall case needs no explicit branch.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_out_nxt   = r_inst_out;
        w_pc_out_nxt     = r_pc_out;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_count_nxt = r_inst_count;

        if (w_waiting) begin
            // Nothing is delivered while idle or halted.
            w_inst_valid_nxt = 1'b0;
            if (r_state != S_HALTED) begin
                w_state_nxt = S_IDLE;
            end
            if (w_do_start) begin
                w_state_nxt      = S_FETCH;
                w_pc_nxt         = i_start_addr;
                w_inst_count_nxt = 16'd0;
            end
        end else if (w_do_halt) begin
            // The PC is frozen so that the halt point stays visible on the
            // ROM address.
            w_state_nxt      = S_HALTED;
            w_inst_valid_nxt = 1'b0;
        end else if (w_do_branch) begin
            // The word the ROM returns at the old PC is discarded. This
            // creates a single bubble before the target word arrives.
            w_pc_nxt         = i_branch_target;
            w_inst_valid_nxt = 1'b0;
        end else if (w_do_seq) begin
            // The PC is IW bits wide, so the increment wraps naturally.
            w_inst_out_nxt   = i_inst_in;
            w_pc_out_nxt     = r_pc;
            w_inst_valid_nxt = 1'b1;
            w_pc_nxt         = r_pc + PC_ONE;
            w_inst_count_nxt = sat_inc16(r_inst_count);
        end
    end

    // State and datapath registers. Reset clears everything asynchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_inst_out   <= '0;
            r_pc_out     <= '0;
            r_inst_valid <= 1'b0;
            r_inst_count <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst_count <= w_inst_count_nxt;
        end
    end

    // Output mapping. The ROM address is the live PC in every state.
    always_comb begin
        o_inst_address = r_pc;
        o_inst_out     = r_inst_out;
        o_inst_valid   = r_inst_valid;
        o_pc_out       = r_pc_out;
        o_done         = (r_state == S_HALTED);
        o_inst_count   = r_inst_count;
    end

endmodule
